// File: rtl/hsuart_pkg.sv
// Shared definitions for the high-speed UART AXI4-Lite register responder:
// register offsets, response codes and FSM state types.
package hsuart_pkg;

  localparam int unsigned AXI_DW = 32;
  localparam int unsigned AXI_AW = 5;

  localparam logic [AXI_AW-1:0] ADDR_CTRL   = 5'h00;
  localparam logic [AXI_AW-1:0] ADDR_BAUD   = 5'h04;
  localparam logic [AXI_AW-1:0] ADDR_TXDATA = 5'h08;
  localparam logic [AXI_AW-1:0] ADDR_RXDATA = 5'h0C;
  localparam logic [AXI_AW-1:0] ADDR_STATUS = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // STATUS register payload, LSB first: tx_full, rx_valid, overrun
  typedef struct packed {
    logic overrun;
    logic rx_valid;
    logic tx_full;
  } status_t;

endpackage

// File: rtl/hsuart_axil_slave.sv
// AXI4-Lite register responder for the high-speed UART: control/baud registers
// plus valid/ready byte handshakes toward the TX and RX cores.
module hsuart_axil_slave
  import hsuart_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [15:0] BAUD_DIV_RST       = 16'd868
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  input  logic                            rx_overrun,
  output logic                            tx_en,
  output logic                            rx_en,
  output logic                            loopback,
  output logic [15:0]                     baud_div
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic              wr_accept, rd_accept, bvalid, rvalid;
  logic [AXI_AW-1:0] aw_off, ar_off;
  logic [1:0]        wr_resp_c, rd_resp_c;
  logic [DW-1:0]     rd_data_c;

  logic [2:0]    ctrl_q;
  logic [15:0]   baud_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q, overrun_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;
  status_t       status;

  // Byte-lane bits and PROT are don't-care for this register file
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WDATA[DW-1:16], S_AXI_WSTRB[3:2]};

  assign aw_off = {S_AXI_AWADDR[4:2], 2'b00};
  assign ar_off = {S_AXI_ARADDR[4:2], 2'b00};
  assign status = '{overrun: overrun_q, rx_valid: rx_valid, tx_full: tx_valid_q};

  // Write FSM: state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state_q <= W_IDLE;
    else          wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_accept = 1'b0;
    bvalid    = 1'b0;
    case (wr_state_q)
      W_IDLE: wr_accept = S_AXI_AWVALID && S_AXI_WVALID;
      W_RESP: bvalid    = 1'b1;
    endcase
  end

  // Read FSM: state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state_q <= R_IDLE;
    else          rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE: if (S_AXI_ARVALID) rd_state_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_accept = 1'b0;
    rvalid    = 1'b0;
    case (rd_state_q)
      R_IDLE: rd_accept = S_AXI_ARVALID;
      R_DATA: rvalid    = 1'b1;
    endcase
  end

  // Write response decode; RXDATA and unmapped offsets are errors
  always_comb begin
    wr_resp_c = RESP_OKAY;
    case (aw_off)
      ADDR_CTRL, ADDR_BAUD, ADDR_STATUS: wr_resp_c = RESP_OKAY;
      ADDR_TXDATA: if (tx_valid_q) wr_resp_c = RESP_SLVERR;
      default:     wr_resp_c = RESP_SLVERR;
    endcase
  end

  // Read mux samples pre-write register state
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (ar_off)
      ADDR_CTRL:   rd_data_c = DW'(ctrl_q);
      ADDR_BAUD:   rd_data_c = DW'(baud_q);
      ADDR_TXDATA: rd_data_c = '0;
      ADDR_RXDATA: rd_data_c = DW'({rx_valid, rx_data});
      ADDR_STATUS: rd_data_c = DW'(status);
      default:     rd_resp_c = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q     <= 3'b000;
      baud_q     <= BAUD_DIV_RST;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;
      if (wr_accept) begin
        bresp_q <= wr_resp_c;
        case (aw_off)
          ADDR_CTRL: if (S_AXI_WSTRB[0]) ctrl_q <= S_AXI_WDATA[2:0];
          ADDR_BAUD: begin
            if (S_AXI_WSTRB[0]) baud_q[7:0]  <= S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) baud_q[15:8] <= S_AXI_WDATA[15:8];
          end
          ADDR_TXDATA: if (S_AXI_WSTRB[0] && !tx_valid_q) begin
            tx_data_q  <= S_AXI_WDATA[7:0];
            tx_valid_q <= 1'b1;
          end
          ADDR_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[2]) overrun_q <= 1'b0;
          default: ;
        endcase
      end
      // Placed after the W1C so a same-cycle overrun wins
      if (rx_overrun) overrun_q <= 1'b1;
      if (rd_accept) begin
        rdata_q <= rd_data_c;
        rresp_q <= rd_resp_c;
      end
    end
  end

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign rx_ready = rd_accept && (ar_off == ADDR_RXDATA) && rx_valid;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_en    = ctrl_q[0];
  assign rx_en    = ctrl_q[1];
  assign loopback = ctrl_q[2];
  assign baud_div = baud_q;

endmodule

// File: doc/hsuart_axil_slave.md
# hsuart_axil_slave

AXI4-Lite register responder for the high-speed UART. It terminates the host-side AXI4-Lite bus driven by the AXI VIP master or the processor. It exposes control, baud, TX-data, RX-data and status registers. It converts register accesses into valid/ready byte handshakes toward the UART TX and RX cores.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; decodes offsets 0x00–0x10.
- BAUD_DIV_RST, 16'd868: reset value of BAUD_DIV.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous assert, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  5/3/1/1  write address channel; PROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  5/3/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- tx_data/tx_valid/tx_ready  out/out/in  8/1/1  byte toward the TX core.
- rx_data/rx_valid/rx_ready  in/in/out  8/1/1  byte from the RX core.
- rx_overrun  in  1  single-cycle pulse from the RX core on a dropped byte.
- tx_en, rx_en, loopback  out  1 each  CTRL[0], CTRL[1], CTRL[2].
- baud_div  out  16  BAUD_DIV[15:0].

## Operation
- Register map (word offsets; ADDR[1:0] ignored):
  - 0x00 CTRL: RW, bits [2:0], reset 0.
  - 0x04 BAUD_DIV: RW, bits [15:0], reset BAUD_DIV_RST.
  - 0x08 TXDATA: WO, reads return 0.
  - 0x0C RXDATA: RO.
  - 0x10 STATUS: {29'b0, overrun, rx_valid, tx_full}.
- WSTRB applies per byte to CTRL and BAUD_DIV.
- TXDATA write with WSTRB[0]=1 and tx_full=0:
  - loads WDATA[7:0] into tx_data and sets tx_valid.
  - tx_valid is held until the cycle tx_valid&&tx_ready, then clears.
  - tx_full is defined as tx_valid.
- TXDATA write while tx_full=1: BRESP=SLVERR (2'b10); holding register unchanged.
- RXDATA read returns {23'b0, rx_valid, rx_data}.
  - If rx_valid=1 at AR accept, rx_ready pulses high for exactly that cycle (pop).
  - If rx_valid=0: no pop, RRESP=OKAY, bit 8 reads 0.
- overrun: sticky, set by rx_overrun. A STATUS write with WDATA[2]=1 and WSTRB[0]=1 clears it (W1C). On a set and clear in the same cycle, set wins.
- Any access outside 0x00–0x10, and writes to RXDATA, return SLVERR.
  - Writes there have no effect.
  - Reads there return RDATA=0.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: when AWVALID&&WVALID, pulse AWREADY and WREADY together for 1 cycle, perform the write, go to W_RESP.
  - W_RESP: BVALID=1 until BREADY, then W_IDLE.
  - AW without W (or W without AW) waits with no ready asserted.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: when ARVALID, pulse ARREADY for 1 cycle, register RDATA/RRESP, go to R_DATA.
  - R_DATA: RVALID=1 until RREADY, then R_IDLE.
- Read and write paths are independent and may complete in the same cycle.
  - A read samples register state before a same-cycle write.

## Timing
- Reset values: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, tx_valid 0, tx_data 0, rx_ready 0, CTRL 0, BAUD_DIV=BAUD_DIV_RST, overrun 0.
- Write latency: AWVALID&&WVALID at cycle N → AWREADY/WREADY high at N → BVALID high at N+1.
- Read latency: ARVALID at N → ARREADY high at N → RVALID high at N+1.
- Throughput: at most 1 write per 2 cycles and 1 read per 2 cycles with BREADY/RREADY tied high.
- tx_valid rises at N+1 after an accepted TXDATA write. The earliest next accepted TXDATA push is the cycle after the tx handshake.
- BVALID, RVALID, RDATA and RRESP stay stable while waiting for READY.
- ARESETN assertion mid-transaction aborts it immediately: VALIDs drop, FSMs return to IDLE, and a pending tx byte is discarded.

## Structure
- Package hsuart_pkg holds:
  - register offset localparams: ADDR_CTRL, ADDR_BAUD, ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS.
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - enums wr_state_t and rd_state_t.
- No sub-modules; one flat module with two FSM always blocks and one register-update block.

## Test plan
- Write CTRL=0x5, BAUD_DIV=0x1234, then read both → 0x5 and 0x1234, BRESP/RRESP=OKAY; outputs tx_en=1, loopback=1, baud_div=0x1234.
- Write TXDATA=0xA5 with tx_ready=0 → tx_valid=1, tx_data=0xA5, STATUS=0x1. A second TXDATA write → SLVERR. Raise tx_ready → tx_valid clears the next cycle.
- Drive rx_valid=1, rx_data=0x3C; read RXDATA → RDATA=0x13C and one-cycle rx_ready. With rx_valid=0, read → 0x000.
- Pulse rx_overrun → STATUS bit2=1. Write STATUS=0x4 → bit2=0. Pulse rx_overrun in the same cycle as the clear → bit2 stays 1.
- Access 0x14: write → SLVERR and no register change; read → RDATA=0, SLVERR.
- Assert ARESETN low while BVALID is held (BREADY=0) and a tx byte is pending → BVALID=0, tx_valid=0, CTRL=0 with no clock edge required.
